fft_input_buffer: RTL and testbench
===================================

Name: fft_input_buffer

Overview:
- Downstream of the Avalon write slave.
- Captures the 256 real 16-bit samples the slave writes (sWriteEn / wAddress / fft_init_data).
- On fft_start, streams the samples to the FFT butterfly engine in bit-reversed order over a valid/ready handshake, then pulses done.
- Writes are only accepted while no stream is in progress.

Parameters:
- NUM_PTS, 256, number of FFT points; power of two.
- ADDR_W, 8, log2(NUM_PTS).
- DATA_W, 16, sample width.

Ports:
- clk  input  1  system clock, rising edge.
- n_rst  input  1  asynchronous active-low reset.
- sWriteEn  input  1  write strobe from the Avalon slave.
- wAddress  input  9  write address; 0..NUM_PTS-1 valid.
- fft_init_data  input  DATA_W  write data.
- fft_start  input  1  single-cycle start pulse.
- out_ready  input  1  FFT engine accepts a sample this cycle.
- out_valid  output  1  out_data/out_index are valid.
- out_data  output  DATA_W  sample for stream position out_index.
- out_index  output  ADDR_W  stream position 0..NUM_PTS-1, natural order.
- busy  output  1  high in STREAM.
- done  output  1  one-cycle pulse after the last transfer.
- wr_err  output  1  sticky error flag.

Behaviour:
- Reset (async, n_rst=0):
  - state=IDLE, cnt=0.
  - All sample words = 0.
  - out_valid=0, out_data=0, out_index=0, busy=0, done=0, wr_err=0.
- Storage: NUM_PTS x DATA_W flop array.
  - Write at the rising edge when sWriteEn=1, state=IDLE and wAddress < NUM_PTS.
  - A write is visible to a read in the next cycle.
- Write faults: wr_err sets and stays 1 until reset; the write is dropped. Faults are:
  - sWriteEn=1 with wAddress >= NUM_PTS, in any state.
  - sWriteEn=1 in STREAM or DONE.
- State IDLE:
  - fft_start=1 -> STREAM next cycle, cnt cleared to 0.
  - A write in the same cycle as fft_start is committed and appears in the stream.
- State STREAM:
  - out_valid=1, busy=1, out_index=cnt.
  - out_data=mem[bitrev(cnt)], where bitrev reverses all ADDR_W bits. This is a combinational read of the registered array; zero latency from cnt.
  - Transfer occurs when out_valid & out_ready. On a transfer cnt increments.
  - Without a transfer, out_data and out_index hold stable. out_ready may toggle arbitrarily.
  - Transfer with cnt=NUM_PTS-1 -> DONE; cnt wraps to 0.
  - fft_start is ignored in STREAM.
- State DONE: done=1, out_valid=0, busy=0 for exactly one cycle, then IDLE. fft_start is ignored in DONE.
- Timing: the first sample is valid the cycle after fft_start. With out_ready held high, NUM_PTS consecutive transfers occur and done asserts at cycle NUM_PTS+1 after fft_start.
- Reset mid-stream: returns to IDLE immediately; the array is cleared; no done pulse.
- Memory is not cleared between runs. Unwritten addresses keep their prior values.

Decomposition:
- fft_pkg holds:
  - Constants NUM_PTS, ADDR_W, DATA_W.
  - typedef enum {IDLE, STREAM, DONE} buf_state_t.
  - Function bitrev(input [ADDR_W-1:0]).
- Sub-module sample_ram, the flop array:
  - Inputs: clk, n_rst, we, waddr, wdata, raddr.
  - Output: rdata, combinational.
- The top module holds the FSM, cnt and error logic.

Test Plan:
- Write mem[i]=i for i=0..255, pulse fft_start, out_ready=1 -> at out_index=1 out_data=128; at out_index=2 out_data=64; at out_index=255 out_data=255; done pulses exactly 257 cycles after fft_start.
- Same load, out_ready toggled 1/0 each cycle -> out_data/out_index hold stable on stall cycles; the sequence is identical to the previous test; 256 transfers total.
- wAddress=9'h100 with sWriteEn=1 -> wr_err=1 and stays 1; no array word changes. sWriteEn=1 during STREAM -> the stream data is unchanged.
- sWriteEn=1, wAddress=0, fft_init_data=16'hBEEF in the same cycle as fft_start -> first streamed out_data=16'hBEEF.
- Assert n_rst=0 at out_index=100 -> all outputs 0 immediately; after release, fft_start streams all-zero data.
- fft_start pulsed again at out_index=10 -> ignored; stream continues to 255; a single done pulse.

Source files
------------

// File: rtl/fft_pkg.sv
// Shared constants, state type and index helper for the FFT input buffer.
// Imported by the sample store and the streaming controller.
package fft_pkg;

    localparam int NUM_PTS = 256;
    localparam int ADDR_W  = 8;
    localparam int DATA_W  = 16;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        STREAM = 2'd1,
        DONE   = 2'd2
    } buf_state_t;

    function automatic logic [ADDR_W-1:0] bitrev(input logic [ADDR_W-1:0] a);
        logic [ADDR_W-1:0] r;
        for (int i = 0; i < ADDR_W; i++) begin
            r[i] = a[ADDR_W-1-i];
        end
        return r;
    endfunction

endpackage

// File: rtl/sample_ram.sv
// Flop-based sample store: one registered write port, one combinational
// read port, whole array cleared by reset.
module sample_ram
    import fft_pkg::*;
(
    input  logic              clk,
    input  logic              n_rst,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic [ADDR_W-1:0] raddr,
    output logic [DATA_W-1:0] rdata
);

    logic [DATA_W-1:0] mem [NUM_PTS];

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            for (int i = 0; i < NUM_PTS; i++) begin
                mem[i] <= '0;
            end
        end else if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/fft_input_buffer.sv
// Captures slave-written samples and streams them out in bit-reversed
// order over valid/ready, pulsing done after the last transfer.
module fft_input_buffer
    import fft_pkg::*;
(
    input  logic              clk,
    input  logic              n_rst,
    input  logic              sWriteEn,
    input  logic [ADDR_W:0]   wAddress,
    input  logic [DATA_W-1:0] fft_init_data,
    input  logic              fft_start,
    input  logic              out_ready,
    output logic              out_valid,
    output logic [DATA_W-1:0] out_data,
    output logic [ADDR_W-1:0] out_index,
    output logic              busy,
    output logic              done,
    output logic              wr_err
);

    buf_state_t        state;
    logic [ADDR_W-1:0] cnt;
    logic [DATA_W-1:0] rdata;
    logic              in_range;
    logic              idle;
    logic              streaming;
    logic              we;

    assign in_range  = wAddress < (ADDR_W+1)'(NUM_PTS);
    assign idle      = state == IDLE;
    assign streaming = state == STREAM;
    assign we        = sWriteEn & idle & in_range;

    sample_ram u_ram (
        .clk   (clk),
        .n_rst (n_rst),
        .we    (we),
        .waddr (wAddress[ADDR_W-1:0]),
        .wdata (fft_init_data),
        .raddr (bitrev(cnt)),
        .rdata (rdata)
    );

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state <= IDLE;
            cnt   <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (fft_start) begin
                        state <= STREAM;
                        cnt   <= '0;
                    end
                end
                STREAM: begin
                    // cnt wraps to 0 on the final transfer
                    if (out_ready) begin
                        cnt <= cnt + 1'b1;
                        if (cnt == ADDR_W'(NUM_PTS-1)) begin
                            state <= DONE;
                        end
                    end
                end
                DONE:    state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            wr_err <= 1'b0;
        end else if (sWriteEn & (~in_range | ~idle)) begin
            wr_err <= 1'b1;
        end
    end

    assign out_valid = streaming;
    assign busy      = streaming;
    assign done      = state == DONE;
    assign out_index = streaming ? cnt : '0;
    assign out_data  = streaming ? rdata : '0;

endmodule

// File: tb/tb_fft_input_buffer.sv
// Directed and randomized checks of the FFT input buffer against an
// array model with arithmetic bit reversal.
module tb_fft_input_buffer;

    localparam int NP = 256;
    localparam int AW = 8;

    logic        clk = 1'b0;
    logic        n_rst;
    logic        sWriteEn;
    logic [8:0]  wAddress;
    logic [15:0] fft_init_data;
    logic        fft_start;
    logic        out_ready;
    logic        out_valid;
    logic [15:0] out_data;
    logic [7:0]  out_index;
    logic        busy;
    logic        done;
    logic        wr_err;

    int checks = 0;
    int fails  = 0;

    logic [15:0] model [NP];
    logic [15:0] seq[$];
    logic [15:0] ref_seq[$];

    always #5 clk = ~clk;

    fft_input_buffer dut (
        .clk           (clk),
        .n_rst         (n_rst),
        .sWriteEn      (sWriteEn),
        .wAddress      (wAddress),
        .fft_init_data (fft_init_data),
        .fft_start     (fft_start),
        .out_ready     (out_ready),
        .out_valid     (out_valid),
        .out_data      (out_data),
        .out_index     (out_index),
        .busy          (busy),
        .done          (done),
        .wr_err        (wr_err)
    );

    function automatic int brev(input int i);
        int r = 0;
        for (int b = 0; b < AW; b++) begin
            if (((i >> b) & 1) == 1) r = r + (1 << (AW - 1 - b));
        end
        return r;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic write(input logic [8:0] a, input logic [15:0] d);
        sWriteEn = 1'b1;
        wAddress = a;
        fft_init_data = d;
        step();
        sWriteEn = 1'b0;
        if (a < 9'(NP)) model[a[7:0]] = d;
    endtask

    task automatic start();
        fft_start = 1'b1;
        step();
        fft_start = 1'b0;
    endtask

    // mode 0: ready always, 1: toggling, 2: random
    task automatic run_stream(input string tag, input int mode,
                              input int pulse_at, input int wr_at);
        int pos = 0;
        int cyc = 1;
        int bad = 0;
        bit r;
        bit prev_x = 1'b1;
        logic [15:0] pd = '0;
        logic [7:0]  pi = '0;
        seq.delete();
        while (pos < NP && cyc < 4000) begin
            if (out_valid !== 1'b1 || busy !== 1'b1 || done !== 1'b0) bad++;
            if (out_index !== 8'(pos)) bad++;
            if (out_data !== model[brev(pos)]) bad++;
            if (!prev_x && (out_data !== pd || out_index !== pi)) bad++;
            pd = out_data;
            pi = out_index;
            case (mode)
                0:       r = 1'b1;
                1:       r = (cyc % 2) == 1;
                default: r = 1'($urandom_range(0, 1));
            endcase
            out_ready = r;
            fft_start = (cyc == pulse_at);
            sWriteEn = (cyc == wr_at);
            wAddress = 9'($urandom_range(0, NP - 1));
            fft_init_data = 16'($urandom);
            step();
            prev_x = r;
            if (r) begin
                seq.push_back(pd);
                pos++;
            end
            cyc++;
        end
        out_ready = 1'b0;
        fft_start = 1'b0;
        sWriteEn = 1'b0;
        chk({tag, "_bad"}, 32'(bad), 0);
        chk({tag, "_len"}, 32'(seq.size()), NP);
        chk({tag, "_done"}, 32'(done), 1);
        if (mode == 0) chk({tag, "_done_cyc"}, 32'(cyc), NP + 1);
        step();
        chk({tag, "_done_gone"}, 32'(done), 0);
        chk({tag, "_idle_valid"}, 32'(out_valid), 0);
    endtask

    initial begin
        int bad;
        n_rst = 1'b0;
        sWriteEn = 1'b0;
        wAddress = '0;
        fft_init_data = '0;
        fft_start = 1'b0;
        out_ready = 1'b0;
        for (int i = 0; i < NP; i++) model[i] = '0;
        #12;
        chk("rst_valid", 32'(out_valid), 0);
        chk("rst_data", 32'(out_data), 0);
        chk("rst_index", 32'(out_index), 0);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_done", 32'(done), 0);
        chk("rst_err", 32'(wr_err), 0);
        step();
        n_rst = 1'b1;
        step();

        for (int i = 0; i < NP; i++) write(9'(i), 16'(i));
        start();
        run_stream("ramp", 0, -1, -1);
        chk("ramp_i0", 32'(seq[0]), 0);
        chk("ramp_i1", 32'(seq[1]), 128);
        chk("ramp_i2", 32'(seq[2]), 64);
        chk("ramp_i255", 32'(seq[255]), 255);
        ref_seq = seq;

        start();
        run_stream("toggle", 1, -1, -1);
        bad = 0;
        for (int i = 0; i < NP && i < seq.size(); i++) begin
            if (seq[i] !== ref_seq[i]) bad++;
        end
        chk("toggle_same", 32'(bad), 0);

        write(9'h100, 16'h1234);
        chk("err_set", 32'(wr_err), 1);
        write(9'h1FF, 16'h5678);
        step();
        chk("err_sticky", 32'(wr_err), 1);
        start();
        run_stream("wr_in_stream", 2, -1, 50);
        chk("err_still", 32'(wr_err), 1);

        for (int i = 0; i < NP; i++) write(9'(i), 16'($urandom));
        sWriteEn = 1'b1;
        wAddress = 9'h000;
        fft_init_data = 16'hBEEF;
        model[0] = 16'hBEEF;
        start();
        sWriteEn = 1'b0;
        run_stream("restart", 0, 11, -1);
        chk("beef_first", 32'(seq[0]), 32'h0000BEEF);

        start();
        out_ready = 1'b1;
        for (int i = 0; i < 100; i++) step();
        chk("mid_index", 32'(out_index), 100);
        n_rst = 1'b0;
        #1;
        chk("mid_rst_valid", 32'(out_valid), 0);
        chk("mid_rst_data", 32'(out_data), 0);
        chk("mid_rst_index", 32'(out_index), 0);
        chk("mid_rst_busy", 32'(busy), 0);
        chk("mid_rst_err", 32'(wr_err), 0);
        out_ready = 1'b0;
        for (int i = 0; i < NP; i++) model[i] = '0;
        step();
        n_rst = 1'b1;
        bad = 0;
        for (int i = 0; i < 3; i++) begin
            step();
            if (done !== 1'b0 || busy !== 1'b0) bad++;
        end
        chk("no_done_after_rst", 32'(bad), 0);
        start();
        run_stream("zeros", 2, -1, -1);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 checks, fails);
        $finish;
    end

endmodule
